// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes, owner
// encoding, mode constants and the access legality helpers.
`include "defs.sv"

package dmem_arb_pkg;

    // Mode codes mirrored from defs.sv so users need only import the package.
    localparam logic [2:0] MODE_LB  = `MEM_LB;
    localparam logic [2:0] MODE_LH  = `MEM_LH;
    localparam logic [2:0] MODE_LW  = `MEM_LW;
    localparam logic [2:0] MODE_LBU = `MEM_LBU;
    localparam logic [2:0] MODE_LHU = `MEM_LHU;
    localparam logic [2:0] MODE_SB  = `MEM_SB;
    localparam logic [2:0] MODE_SH  = `MEM_SH;
    localparam logic [2:0] MODE_SW  = `MEM_SW;

    // Response-slot FSM: IDLE = slot empty, RESP = slot holds a response.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // Which master owns the response slot.
    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    // A load must carry a load code, a store must carry a store code.
    function automatic logic is_legal_mode(input logic we, input logic [2:0] mode);
        logic ok;
        if (we) begin
            ok = (mode == MODE_SB) || (mode == MODE_SH) || (mode == MODE_SW);
        end else begin
            ok = (mode == MODE_LB) || (mode == MODE_LH) || (mode == MODE_LW) ||
                 (mode == MODE_LBU) || (mode == MODE_LHU);
        end
        return ok;
    endfunction

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if ((mode == MODE_LW) || (mode == MODE_SW)) begin
            mis = (lo != 2'b00);
        end else if ((mode == MODE_LH) || (mode == MODE_LHU) || (mode == MODE_SH)) begin
            mis = lo[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/defs.sv
// Memory access mode codes shared by the data memory and its masters.
// Loads and stores use disjoint codes so a store carrying a load code
// (or vice versa) can be recognised as illegal.
`ifndef DMEM_DEFS_SV
`define DMEM_DEFS_SV

`define MEM_LB  3'b000
`define MEM_LH  3'b001
`define MEM_LW  3'b010
`define MEM_SW  3'b011
`define MEM_LBU 3'b100
`define MEM_LHU 3'b101
`define MEM_SB  3'b110
`define MEM_SH  3'b111

`endif

// File: rtl/rr_arb2.sv
// Two-requester arbiter producing a one-hot grant. With both requesting,
// round-robin picks the master that did not win last; fixed priority
// always picks master 0. Nothing is granted while en_i is low.
module rr_arb2 (
    input  logic       rr_en_i,
    input  logic       en_i,
    input  logic       rr_last_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

    // One-hot grant selection.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                if (rr_en_i && !rr_last_i) begin
                    gnt_o = 2'b10;
                end else begin
                    gnt_o = 2'b01;
                end
            end else begin
                gnt_o = valid_i;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Master 0 is the load/store unit, master 1 the debug/DMA port. Each
// accepted access drives the memory combinationally in the accept cycle
// and returns its response from a single registered slot one cycle later.
// Illegal, misaligned or out-of-range accesses get an error response and
// never write memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter bit          RR_EN       = 1'b1,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    input  logic        m0_we_i,
    input  logic [2:0]  m0_mode_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rsp_err_o,

    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    input  logic        m1_we_i,
    input  logic [2:0]  m1_mode_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rsp_err_o,

    output logic        mem_we_o,
    output logic [2:0]  mem_mode_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH_WORDS);

    logic [0:0]  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        rr_last_q, rr_last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        rsp_pend;
    logic        m0_rsp_valid;
    logic        m1_rsp_valid;
    logic        rsp_done;
    logic        slot_free;
    logic [1:0]  gnt;
    logic        acc;

    logic        sel_we;
    logic [2:0]  sel_mode;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        out_of_range;
    logic        req_err;

    // Response slot status; only the owner ever sees a valid response.
    always_comb begin
        rsp_pend     = (state_q == ST_RESP);
        m0_rsp_valid = rsp_pend & (owner_q == OWN_M0);
        m1_rsp_valid = rsp_pend & (owner_q == OWN_M1);
        rsp_done     = (m0_rsp_valid & m0_rsp_ready_i) | (m1_rsp_valid & m1_rsp_ready_i);
        // The slot can take a new access in the same cycle the old response
        // is consumed; nothing is granted while reset is held.
        slot_free    = rst_n & (~rsp_pend | rsp_done);
    end

    rr_arb2 u_rr_arb2 (
        .rr_en_i   (RR_EN),
        .en_i      (slot_free),
        .rr_last_i (rr_last_q),
        .valid_i   ({m1_req_valid_i, m0_req_valid_i}),
        .gnt_o     (gnt)
    );

    assign m0_req_ready_o = gnt[0];
    assign m1_req_ready_o = gnt[1];
    assign acc            = |gnt;

    // Route the granted master's request and classify it.
    always_comb begin
        if (gnt[1]) begin
            sel_we    = m1_we_i;
            sel_mode  = m1_mode_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end else begin
            sel_we    = m0_we_i;
            sel_mode  = m0_mode_i;
            sel_addr  = m0_addr_i;
            sel_wdata = m0_wdata_i;
        end
        out_of_range = (sel_addr[31:2] >= WORD_LIMIT);
        req_err      = ~is_legal_mode(sel_we, sel_mode) |
                       (CHECK_ALIGN & is_misaligned(sel_mode, sel_addr[1:0])) |
                       out_of_range;
    end

    // Memory port: driven only in an accept cycle, parked otherwise.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_mode_o = MODE_LW;
        mem_a_o    = '0;
        mem_wd_o   = '0;
        if (acc) begin
            mem_we_o   = sel_we & ~req_err;
            mem_mode_o = sel_mode;
            mem_a_o    = sel_addr;
            mem_wd_o   = sel_wdata;
        end
    end

    // Next-state: load the slot on accept, otherwise empty it on handshake.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (acc) begin
            state_d   = ST_RESP;
            owner_d   = gnt[1] ? OWN_M1 : OWN_M0;
            rr_last_d = gnt[1];
            rdata_d   = (~sel_we & ~req_err) ? mem_rd_i : 32'h0;
            err_d     = req_err;
        end else if (rsp_done) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; reset leaves m1 as last winner so m0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_M0;
            rr_last_q <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Shared response registers, gated so the non-owner sees zeros.
    always_comb begin
        m0_rsp_valid_o = m0_rsp_valid;
        m1_rsp_valid_o = m1_rsp_valid;
        m0_rdata_o     = m0_rsp_valid ? rdata_q : 32'h0;
        m1_rdata_o     = m1_rsp_valid ? rdata_q : 32'h0;
        m0_rsp_err_o   = m0_rsp_valid & err_q;
        m1_rsp_err_o   = m1_rsp_valid & err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word memory with extending reads sits behind
// the arbiter, and a transaction-level model predicts grants, memory
// port activity and responses from per-master request queues.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        bit        we;
        bit [2:0]  mode;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [2:0]  m0_mode;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [2:0]  m1_mode;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic        fp_m0_req_ready, fp_m1_req_ready, fp_m0_rsp_valid, fp_m1_rsp_valid;
    logic        fp_m0_rsp_err, fp_m1_rsp_err, fp_mem_we;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_a, fp_mem_wd;
    logic [2:0]  fp_mem_mode;
    logic [31:0] fp_mem_rd;

    logic        mem_init;
    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];

    int          vectors = 0;
    int          miscompares = 0;
    req_t        q0[$];
    req_t        q1[$];
    req_t        cur0, cur1;
    bit          pend_valid;
    int          pend_owner;
    bit [31:0]   pend_data;
    bit          pend_err;
    int          last_win_ref;
    int          last_acc;
    int          n_acc;
    bit          fp_check;
    int          win_log [8];

    always #5 clk = ~clk;
    assign fp_mem_rd = 32'h0;

    dmem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready), .m0_we_i(m0_we),
        .m0_mode_i(m0_mode), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready),
        .m0_rdata_o(m0_rdata), .m0_rsp_err_o(m0_rsp_err),
        .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready), .m1_we_i(m1_we),
        .m1_mode_i(m1_mode), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready),
        .m1_rdata_o(m1_rdata), .m1_rsp_err_o(m1_rsp_err),
        .mem_we_o(mem_we), .mem_mode_o(mem_mode), .mem_a_o(mem_a), .mem_wd_o(mem_wd),
        .mem_rd_i(mem_rd)
    );

    dmem_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(fp_m0_req_ready), .m0_we_i(m0_we),
        .m0_mode_i(m0_mode), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rsp_valid_o(fp_m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready),
        .m0_rdata_o(fp_m0_rdata), .m0_rsp_err_o(fp_m0_rsp_err),
        .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(fp_m1_req_ready), .m1_we_i(m1_we),
        .m1_mode_i(m1_mode), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rsp_valid_o(fp_m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready),
        .m1_rdata_o(fp_m1_rdata), .m1_rsp_err_o(fp_m1_rsp_err),
        .mem_we_o(fp_mem_we), .mem_mode_o(fp_mem_mode), .mem_a_o(fp_mem_a),
        .mem_wd_o(fp_mem_wd), .mem_rd_i(fp_mem_rd)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 5) return 32'h8000_00F0;
        return 32'h5A3C_96E1 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Memory read with byte/half extraction and sign/zero extension.
    function automatic logic [31:0] load_ext(logic [31:0] w, logic [2:0] mode, logic [1:0] lo);
        logic [31:0] b, h;
        b = w >> (32'(lo) * 8);
        h = w >> (lo[1] ? 16 : 0);
        case (mode)
            MODE_LB:  return {{24{b[7]}}, b[7:0]};
            MODE_LBU: return {24'h0, b[7:0]};
            MODE_LH:  return {{16{h[15]}}, h[15:0]};
            MODE_LHU: return {16'h0, h[15:0]};
            default:  return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(logic [31:0] w, logic [2:0] mode, logic [1:0] lo,
                                                logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (mode)
            MODE_SB: r[32'(lo)*8 +: 8] = d[7:0];
            MODE_SH: r[(lo[1] ? 16 : 0) +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int size_of(bit [2:0] mode);
        if (mode == MODE_LW || mode == MODE_SW) return 4;
        if (mode == MODE_LH || mode == MODE_LHU || mode == MODE_SH) return 2;
        return 1;
    endfunction

    // Rejection rule stated directly: wrong code class, misaligned, or past the end.
    function automatic bit ref_err(req_t r);
        bit legal;
        if (r.we) legal = r.mode inside {MODE_SB, MODE_SH, MODE_SW};
        else      legal = r.mode inside {MODE_LB, MODE_LH, MODE_LW, MODE_LBU, MODE_LHU};
        return !legal || (r.addr % size_of(r.mode) != 0) || (r.addr / 4 >= 64);
    endfunction

    always_comb mem_rd = load_ext(env_mem[mem_a[7:2]], mem_mode, mem_a[1:0]);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_val(i);
        end else if (mem_we) begin
            env_mem[mem_a[7:2]] <= store_merge(env_mem[mem_a[7:2]], mem_mode, mem_a[1:0], mem_wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_valid   = 1'b0;
        last_win_ref = 1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   sz;
        r.we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) begin
            if (r.we) begin
                case ($urandom_range(0, 2))
                    0: r.mode = MODE_SB;
                    1: r.mode = MODE_SH;
                    default: r.mode = MODE_SW;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0: r.mode = MODE_LB;
                    1: r.mode = MODE_LH;
                    2: r.mode = MODE_LW;
                    3: r.mode = MODE_LBU;
                    default: r.mode = MODE_LHU;
                endcase
            end
        end else begin
            r.mode = 3'($urandom_range(0, 7));
        end
        sz = size_of(r.mode);
        r.addr = 32'($urandom_range(0, 67)) * 4;
        if ($urandom_range(0, 9) < 9) r.addr += 32'(($urandom_range(0, 3) / sz) * sz);
        else                          r.addr += 32'($urandom_range(0, 3));
        r.wdata = $urandom;
        return r;
    endfunction

    // One clock: present queued requests, check against the model at the
    // falling edge, then advance the model past the rising edge.
    task automatic cycle();
        req_t      r;
        int        win;
        bit        free;
        bit        e_err, ewe;
        bit [31:0] e_rd, ea, ewd;
        bit [2:0]  emode;
        if (!m0_req_valid && q0.size() > 0) begin
            cur0 = q0.pop_front();
            m0_we = cur0.we; m0_mode = cur0.mode; m0_addr = cur0.addr; m0_wdata = cur0.wdata;
            m0_req_valid = 1'b1;
        end
        if (!m1_req_valid && q1.size() > 0) begin
            cur1 = q1.pop_front();
            m1_we = cur1.we; m1_mode = cur1.mode; m1_addr = cur1.addr; m1_wdata = cur1.wdata;
            m1_req_valid = 1'b1;
        end
        @(negedge clk);
        check("m0_rsp_valid", m0_rsp_valid, pend_valid && pend_owner == 0);
        check("m1_rsp_valid", m1_rsp_valid, pend_valid && pend_owner == 1);
        if (pend_valid && pend_owner == 0) begin
            check("m0_rdata", m0_rdata, pend_data);
            check("m0_rsp_err", m0_rsp_err, pend_err);
        end
        if (pend_valid && pend_owner == 1) begin
            check("m1_rdata", m1_rdata, pend_data);
            check("m1_rsp_err", m1_rsp_err, pend_err);
        end
        free = !pend_valid || (pend_owner == 0 ? m0_rsp_ready : m1_rsp_ready);
        win = -1;
        if (free) begin
            if (m0_req_valid && m1_req_valid) win = (last_win_ref == 0) ? 1 : 0;
            else if (m0_req_valid)            win = 0;
            else if (m1_req_valid)            win = 1;
        end
        check("m0_req_ready", m0_req_ready, win == 0);
        check("m1_req_ready", m1_req_ready, win == 1);
        e_err = 1'b0; e_rd = 32'h0;
        if (win >= 0) begin
            r = (win == 0) ? cur0 : cur1;
            e_err = ref_err(r);
            ewe = r.we && !e_err; ea = r.addr; emode = r.mode; ewd = r.wdata;
            if (!r.we && !e_err) e_rd = load_ext(ref_mem[r.addr[7:2]], r.mode, r.addr[1:0]);
        end else begin
            ewe = 1'b0; ea = 32'h0; emode = MODE_LW; ewd = 32'h0;
        end
        check("mem_we", mem_we, ewe);
        check("mem_a", mem_a, ea);
        check("mem_mode", mem_mode, emode);
        check("mem_wd", mem_wd, ewd);
        if (fp_check && m0_req_valid) begin
            check("fp_m0_ready", fp_m0_req_ready, 1);
            check("fp_m1_ready", fp_m1_req_ready, 0);
        end
        @(posedge clk);
        #1;
        last_acc = win;
        if (win >= 0) begin
            pend_valid = 1'b1; pend_owner = win; pend_data = e_rd; pend_err = e_err;
            last_win_ref = win;
            if (r.we && !e_err)
                ref_mem[r.addr[7:2]] = store_merge(ref_mem[r.addr[7:2]], r.mode, r.addr[1:0], r.wdata);
            if (win == 0) m0_req_valid = 1'b0;
            else          m1_req_valid = 1'b0;
            n_acc++;
            $display("txn m%0d we=%0d mode=%0d addr=%h wdata=%h err=%0d rdata=%h",
                     win, r.we, r.mode, r.addr, r.wdata, e_err, e_rd);
        end else if (free && pend_valid) begin
            pend_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_init = 1'b1; fp_check = 1'b0; n_acc = 0;
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_mode = MODE_LW; m0_addr = 0; m0_wdata = 0;
        m1_req_valid = 1'b1; m1_we = 1'b0; m1_mode = MODE_LW; m1_addr = 4; m1_wdata = 0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        model_reset();

        // Reset: no grants and no writes even with requests pending.
        @(posedge clk); #1;
        check("rst_m0_ready", m0_req_ready, 0);
        check("rst_m1_ready", m1_req_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_m0_rsp_valid", m0_rsp_valid, 0);
        check("rst_m1_rsp_valid", m1_rsp_valid, 0);
        @(posedge clk); #1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; mem_init = 1'b0; rst_n = 1'b1;

        // Single sign-extended byte load.
        q0.push_back('{1'b0, MODE_LB, 32'h14, 32'h0});
        cycle();
        check("lb_rsp_valid", m0_rsp_valid, 1);
        check("lb_rdata", m0_rdata, 32'hFFFF_FFF0);
        check("lb_err", m0_rsp_err, 0);
        cycle();

        // Backpressure: m0 response held, m1 must wait, then goes same cycle.
        m0_rsp_ready = 1'b0;
        q0.push_back('{1'b0, MODE_LW, 32'h14, 32'h0});
        cycle();
        q1.push_back('{1'b0, MODE_LW, 32'h0C, 32'h0});
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_no_grant", last_acc, -1);
            check("bp_rdata_stable", m0_rdata, 32'h8000_00F0);
        end
        m0_rsp_ready = 1'b1;
        cycle();
        check("bp_m1_same_cycle", last_acc, 1);
        cycle();

        // Rejected accesses: error response, zero data, memory untouched.
        q0.push_back('{1'b1, MODE_SW, 32'h22, 32'h1111_1111});
        q0.push_back('{1'b1, MODE_SH, 32'h21, 32'h2222_2222});
        q0.push_back('{1'b0, MODE_LW, 32'h100, 32'h0});
        q0.push_back('{1'b1, MODE_LB, 32'h24, 32'h3333_3333});
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("err_flag", m0_rsp_err, 1);
            check("err_rdata", m0_rdata, 0);
        end
        cycle();
        check("err_word8", env_mem[8], init_val(8));
        check("err_word9", env_mem[9], init_val(9));

        // Store from m1, then halfword load from m0 sees it.
        q1.push_back('{1'b1, MODE_SW, 32'h08, 32'hDEAD_BEEF});
        cycle();
        q0.push_back('{1'b0, MODE_LHU, 32'h08, 32'h0});
        cycle();
        check("lhu_rdata", m0_rdata, 32'h0000_BEEF);
        cycle();

        // Both masters streaming with responses always consumed.
        for (int i = 0; i < 5; i++) begin
            q0.push_back('{1'b0, MODE_LW, 32'(i * 4), 32'h0});
            q1.push_back('{1'b0, MODE_LW, 32'(64 + i * 4), 32'h0});
        end
        n_acc = 0; fp_check = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            win_log[i] = last_acc;
        end
        fp_check = 1'b0;
        check("stream_accepts", n_acc, 8);
        for (int i = 1; i < 8; i++)
            check("stream_alternate", win_log[i], (i % 2 == 0) ? win_log[0] : 1 - win_log[0]);
        repeat (4) cycle();

        // Reset while m1's response is pending.
        m1_rsp_ready = 1'b0;
        q1.push_back('{1'b0, MODE_LW, 32'h0C, 32'h0});
        cycle();
        check("pre_rst_m1_valid", m1_rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_m1_valid", m1_rsp_valid, 0);
        check("midrst_m0_ready", m0_req_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; m1_rsp_ready = 1'b1;
        q0.push_back('{1'b0, MODE_LW, 32'h10, 32'h0});
        q1.push_back('{1'b0, MODE_LW, 32'h18, 32'h0});
        cycle();
        check("post_rst_m0_first", last_acc, 0);
        cycle();
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            if (q0.size() == 0 && !m0_req_valid && $urandom_range(0, 2) != 0) q0.push_back(rand_req());
            if (q1.size() == 0 && !m1_req_valid && $urandom_range(0, 2) != 0) q1.push_back(rand_req());
            cycle();
        end

        // Drain, then compare the whole memory.
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        repeat (6) cycle();
        check("drain_m0_valid", m0_req_valid, 0);
        check("drain_m1_valid", m1_req_valid, 0);
        for (int i = 0; i < 64; i++) check("mem_word", env_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory. It shares the memory between the core load/store unit (m0) and a debug/DMA master (m1) using valid/ready request and response handshakes, with round-robin or fixed priority. It rejects misaligned, out-of-range or illegal-mode accesses with an error response and no memory write. Each accepted access returns its response in a registered slot one cycle later.

Parameters:
DEPTH_WORDS, 64, memory depth in 32-bit words; word index addr[31:2] >= DEPTH_WORDS is out of range
RR_EN, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins
CHECK_ALIGN, 1, 1 = enforce natural alignment per mode; 0 = pass any address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req_valid  in  1  m0 request valid
m0_req_ready  out  1  m0 request accepted this cycle
m0_we  in  1  1 = store, 0 = load
m0_mode  in  3  access mode, `MEM_* codes from defs.sv
m0_addr  in  32  byte address
m0_wdata  in  32  store data
m0_rsp_valid  out  1  m0 response valid
m0_rsp_ready  in  1  m0 response consumed
m0_rdata  out  32  load data, already extended by memory
m0_rsp_err  out  1  access rejected
m1_*  same set and widths as m0_*, for master 1
mem_we  out  1  memory write enable
mem_mode  out  3  memory access mode
mem_a  out  32  memory address
mem_wd  out  32  memory write data
mem_rd  in  32  memory combinational read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rsp valid flags 0, rdata regs 0, err regs 0, rr_last=1 (so m0 has priority first).
- Combinational outputs while reset is asserted: all req_ready=0, mem_we=0.
- States: IDLE (response slot empty) and RESP (response slot holds data for owner ∈ {m0,m1}).
- Slot free condition: state==IDLE, or state==RESP and the owner's rsp_valid & rsp_ready are both high this cycle.
- Grant:
  - Only while the slot is free.
  - With one valid request, that master is granted.
  - With both valid and RR_EN=1, the master ≠ rr_last is granted. With RR_EN=0, m0 is granted.
  - Grant is combinational; req_ready is high for the granted master only.
- Accept cycle (req_valid & req_ready):
  - mem_a, mem_mode and mem_wd are driven from the granted master the same cycle.
  - mem_we = granted we & ~err.
  - mem_rd is captured into the response rdata register at the clock edge: the loaded value for a load, 0 for a store or on error.
  - err is captured into the response err register.
  - Owner and rr_last are set to the granted master. State goes to RESP.
- Memory outputs when no accept occurs: mem_we=0, mem_a=0, mem_wd=0, mem_mode=`MEM_LW.
- err conditions: mode not a legal load code (we=0) or store code (we=1); CHECK_ALIGN and misalignment; out-of-range word index.
  - Misaligned for word modes: addr[1:0]≠0.
  - Misaligned for halfword modes: addr[0]≠0.
- Latency: response valid exactly 1 cycle after accept.
- Throughput: 1 access/cycle when rsp_ready is held high, because a new accept is allowed in the same cycle as the response handshake.
- Response held: rsp_valid, rdata and err stay stable until rsp_ready. If no new accept occurs in the handshake cycle, state returns to IDLE.
- Non-owner outputs: the non-owner's rsp_valid is always 0. Both masters' rdata/err may be shared registers gated by owner.
- Master obligations: a master holds valid, we, mode, addr and wdata stable until ready. The arbiter never drops a valid request, and fairness guarantees grant within 2 accepts.
- Reset mid-operation: a pending response is discarded. Stores already written stay in memory.

Decomposition:
- Package dmem_arb_pkg: state enum {IDLE, RESP}; owner encoding; a function is_legal_mode(we, mode); a function is_misaligned(mode, addr[1:0]). Mode codes stay in defs.sv.
- One natural sub-module: rr_arb2. It takes the two valids, rr_last, RR_EN and a free enable, and returns a one-hot grant.

Test Plan:
- Single load: memory word 5 = 0x8000_00F0; m0 issues LB at addr 0x14 -> mem_we=0, one cycle later m0_rsp_valid=1, m0_rdata=0xFFFF_FFF0, err=0.
- Both masters streaming, rsp_ready=1:
  - RR_EN=1, 8 cycles -> grants alternate m0,m1,m0,…; 8 accepts in 8 cycles.
  - RR_EN=0 -> m1 is never granted while m0_req_valid stays high.
- Backpressure: m0 response pending with m0_rsp_ready=0 for 3 cycles while m1 is valid -> m1_req_ready=0 throughout and m0_rdata stable. On m0_rsp_ready=1, m1 is accepted in the same cycle.
- Error cases, each gives rsp_err=1, rdata=0 and no write, with memory contents verified unchanged:
  - SW at 0x22.
  - SH at 0x21.
  - LW at word index 64.
  - Store with a load mode code.
- Store then load: m1 SW 0xDEADBEEF at 0x08, then m0 LHU at 0x08 -> m0_rdata=0x0000_BEEF.
- Reset mid-operation: assert rst_n=0 while RESP holds m1 data -> rsp_valid drops immediately. After release, m0 wins first simultaneous request.
